// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
// Shared definitions for the hardwired control unit: field widths, opcode
// constants, ALU function codes and the controller state encoding.
// No ports; imported by control_sequencer.
package control_sequencer_pkg;

    localparam int OPW  = 5;   // opcode width, IR[31:27]
    localparam int STW  = 5;   // state register width
    localparam int ALUW = 4;   // AluOp width

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [ALUW-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUW-1:0] ALU_PASS = 4'd1;

    typedef enum logic [STW-1:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_STOP,
        S_HALT
    } state_t;

endpackage

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit. Steps the fetch sequence (T0-T2), decodes the
// opcode in IR[31:27] and walks the execute steps, one clock per T-step,
// driving every datapath strobe.
// Ports:
//   Clock, Reset_n        clock and synchronous active-low reset
//   IR[31:0]              instruction register contents (used from T3 on)
//   CON                   branch condition, only looked at in BR T6
//   Stop                  park in S_STOP between instructions while high
//   *in / *out strobes    register load and bus drive enables
//   Gra,Grb,Grc,Rin,Rout,BAout   register file select/enable
//   Read, write, IncPC    memory read/write and PC increment
//   AluOp[3:0]            ALU function
//   Run                   high while an instruction is being sequenced
//   IllegalOp             one-cycle pulse in T3 for an unsupported opcode
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        INPORTin,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        HIout,
    output logic        LOout,
    output logic        INPORTout,
    output logic        OUTPORTout,
    output logic        Yout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        write,
    output logic        IncPC,
    output logic [3:0]  AluOp,
    output logic        Run,
    output logic        IllegalOp
);

    state_t           state;
    state_t           next_state;
    state_t           after_instr;
    logic [OPW-1:0]   opcode;
    logic             unused_ir_bits;

    assign opcode = IR[31:27];

    // The register fields are consumed by the datapath select logic, not here.
    assign unused_ir_bits = ^IR[26:0];

    // Stop is only honoured at an instruction boundary.
    assign after_instr = Stop ? S_STOP : S_T0;

    assign Run = (state inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7});

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from the current state and opcode; the only other
    // input that reaches an output is CON, which gates the BR T6 step.
    always_comb begin
        PCin       = 1'b0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        CONin      = 1'b0;
        INPORTin   = 1'b0;
        PCout      = 1'b0;
        MDRout     = 1'b0;
        ZHIout     = 1'b0;
        ZLOout     = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        INPORTout  = 1'b0;
        OUTPORTout = 1'b0;
        Yout       = 1'b0;
        Cout       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        BAout      = 1'b0;
        Read       = 1'b0;
        write      = 1'b0;
        IncPC      = 1'b0;
        AluOp      = ALU_ADD;
        IllegalOp  = 1'b0;
        next_state = state;

        case (state)
            S_RST: next_state = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Read = 1'b1; MDRin = 1'b1; PCin = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                next_state = S_T4;
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_ADDI:              begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_BR:                begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_NOP:               next_state = after_instr;
                    OP_HALT:              next_state = S_HALT;
                    default: begin
                        IllegalOp  = 1'b1;
                        next_state = after_instr;
                    end
                endcase
            end
            S_T4: begin
                next_state = S_T5;
                case (opcode)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        Cout = 1'b1; AluOp = ALU_ADD; Zin = 1'b1;
                    end
                    OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                    default: next_state = after_instr;
                endcase
            end
            S_T5: begin
                next_state = S_T6;
                case (opcode)
                    OP_LD, OP_ST: begin ZLOout = 1'b1; MARin = 1'b1; end
                    OP_LDI, OP_ADDI: begin
                        ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        next_state = after_instr;
                    end
                    OP_BR:   begin Cout = 1'b1; AluOp = ALU_ADD; Zin = 1'b1; end
                    default: next_state = after_instr;
                endcase
            end
            S_T6: begin
                next_state = S_T7;
                case (opcode)
                    OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_BR: begin
                        ZLOout     = CON;
                        PCin       = CON;
                        next_state = after_instr;
                    end
                    default: next_state = after_instr;
                endcase
            end
            S_T7: begin
                next_state = after_instr;
                case (opcode)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   write = 1'b1;
                    default: ;
                endcase
            end
            S_STOP:  next_state = Stop ? S_STOP : S_T0;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Directed bench for control_sequencer: walks reset, each supported
// instruction, Stop handling, HALT and an illegal opcode, comparing the full
// strobe pattern every cycle against hand-written expectations.
module tb_control_sequencer;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] IR;
    logic        CON;
    logic        Stop;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, INPORTin;
    logic PCout, MDRout, ZHIout, ZLOout, HIout, LOout, INPORTout, OUTPORTout, Yout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC;
    logic [3:0] AluOp;
    logic Run, IllegalOp;

    int compare_count = 0;
    int fail_count    = 0;

    localparam logic [31:0] I_LD   = 32'h00800075;
    localparam logic [31:0] I_ST   = 32'h12000090;
    localparam logic [31:0] I_BR   = 32'h93000014;
    localparam logic [31:0] I_LDI  = 32'h09900025;
    localparam logic [31:0] I_ADDI = 32'h60000003;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_BAD  = 32'hF8000000;

    localparam logic [28:0] M_PCIN   = 29'h1 << 28;
    localparam logic [28:0] M_IRIN   = 29'h1 << 27;
    localparam logic [28:0] M_MARIN  = 29'h1 << 26;
    localparam logic [28:0] M_MDRIN  = 29'h1 << 25;
    localparam logic [28:0] M_YIN    = 29'h1 << 24;
    localparam logic [28:0] M_ZIN    = 29'h1 << 23;
    localparam logic [28:0] M_CONIN  = 29'h1 << 20;
    localparam logic [28:0] M_PCOUT  = 29'h1 << 18;
    localparam logic [28:0] M_MDROUT = 29'h1 << 17;
    localparam logic [28:0] M_ZLOOUT = 29'h1 << 15;
    localparam logic [28:0] M_COUT   = 29'h1 << 9;
    localparam logic [28:0] M_GRA    = 29'h1 << 8;
    localparam logic [28:0] M_GRB    = 29'h1 << 7;
    localparam logic [28:0] M_RIN    = 29'h1 << 5;
    localparam logic [28:0] M_ROUT   = 29'h1 << 4;
    localparam logic [28:0] M_BAOUT  = 29'h1 << 3;
    localparam logic [28:0] M_READ   = 29'h1 << 2;
    localparam logic [28:0] M_WRITE  = 29'h1 << 1;
    localparam logic [28:0] M_INCPC  = 29'h1 << 0;
    // Every bus driver: PCout..Cout plus Rout and BAout.
    localparam logic [28:0] BUS_MASK = 29'h0007FE18;
    localparam logic [28:0] NONE     = 29'h0;

    logic [28:0] observed;
    assign observed = {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, INPORTin,
                       PCout, MDRout, ZHIout, ZLOout, HIout, LOout, INPORTout, OUTPORTout,
                       Yout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC};

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON(CON), .Stop(Stop),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .INPORTin(INPORTin),
        .PCout(PCout), .MDRout(MDRout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .HIout(HIout), .LOout(LOout), .INPORTout(INPORTout), .OUTPORTout(OUTPORTout),
        .Yout(Yout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Read(Read), .write(write), .IncPC(IncPC),
        .AluOp(AluOp), .Run(Run), .IllegalOp(IllegalOp)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Drives every DUT input at once.
    task automatic applyStimulus(input logic rst_n, input logic [31:0] ir,
                                 input logic con, input logic stop);
        Reset_n = rst_n;
        IR      = ir;
        CON     = con;
        Stop    = stop;
    endtask

    // Compares strobes, AluOp, Run, IllegalOp and the single-driver rule.
    task automatic checkOutput(input string tag, input logic [28:0] exp_strobes,
                               input logic [3:0] exp_alu, input logic exp_run,
                               input logic exp_ill);
        logic bus_ok;
        bus_ok = ($countones(observed & BUS_MASK) <= 1);
        compare_count++;
        assert (observed === exp_strobes) else begin
            fail_count++;
            $error("[TB] FAIL %s strobes: got %h expected %h", tag, observed, exp_strobes);
        end
        compare_count++;
        assert (AluOp === exp_alu) else begin
            fail_count++;
            $error("[TB] FAIL %s AluOp: got %h expected %h", tag, AluOp, exp_alu);
        end
        compare_count++;
        assert (Run === exp_run) else begin
            fail_count++;
            $error("[TB] FAIL %s Run: got %b expected %b", tag, Run, exp_run);
        end
        compare_count++;
        assert (IllegalOp === exp_ill) else begin
            fail_count++;
            $error("[TB] FAIL %s IllegalOp: got %b expected %b", tag, IllegalOp, exp_ill);
        end
        compare_count++;
        assert (bus_ok === 1'b1) else begin
            fail_count++;
            $error("[TB] FAIL %s bus_drivers: got %h expected at most one", tag,
                   observed & BUS_MASK);
        end
    endtask

    // Advances one clock and samples 1 time unit after the edge.
    task automatic stepCheck(input string tag, input logic [28:0] exp_strobes,
                             input logic exp_run);
        @(posedge Clock);
        #1;
        checkOutput(tag, exp_strobes, 4'd0, exp_run, 1'b0);
    endtask

    // Fetch T0-T2; the next instruction word is presented once T0 is checked.
    task automatic runFetch(input string tag, input logic [31:0] ir,
                            input logic con, input logic stop);
        stepCheck({tag, "_T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b1);
        applyStimulus(1'b1, ir, con, stop);
        stepCheck({tag, "_T1"}, M_READ | M_MDRIN | M_PCIN, 1'b1);
        stepCheck({tag, "_T2"}, M_MDROUT | M_IRIN, 1'b1);
    endtask

    initial begin
        $display("[TB] control_sequencer directed test");
        applyStimulus(1'b0, I_LD, 1'b0, 1'b0);
        stepCheck("reset_0", NONE, 1'b0);
        stepCheck("reset_1", NONE, 1'b0);

        // LD interrupted by reset in T5
        applyStimulus(1'b1, I_LD, 1'b0, 1'b0);
        runFetch("ld_abort", I_LD, 1'b0, 1'b0);
        stepCheck("ld_abort_T3", M_GRB | M_BAOUT | M_YIN, 1'b1);
        stepCheck("ld_abort_T4", M_COUT | M_ZIN, 1'b1);
        stepCheck("ld_abort_T5", M_ZLOOUT | M_MARIN, 1'b1);
        applyStimulus(1'b0, I_LD, 1'b0, 1'b0);
        stepCheck("mid_reset_0", NONE, 1'b0);
        stepCheck("mid_reset_1", NONE, 1'b0);
        applyStimulus(1'b1, I_LD, 1'b0, 1'b0);

        // Full LD
        runFetch("ld", I_LD, 1'b0, 1'b0);
        stepCheck("ld_T3", M_GRB | M_BAOUT | M_YIN, 1'b1);
        stepCheck("ld_T4", M_COUT | M_ZIN, 1'b1);
        stepCheck("ld_T5", M_ZLOOUT | M_MARIN, 1'b1);
        stepCheck("ld_T6", M_READ | M_MDRIN, 1'b1);
        stepCheck("ld_T7", M_MDROUT | M_GRA | M_RIN, 1'b1);

        // ST
        runFetch("st", I_ST, 1'b0, 1'b0);
        stepCheck("st_T3", M_GRB | M_BAOUT | M_YIN, 1'b1);
        stepCheck("st_T4", M_COUT | M_ZIN, 1'b1);
        stepCheck("st_T5", M_ZLOOUT | M_MARIN, 1'b1);
        stepCheck("st_T6", M_GRA | M_ROUT | M_MDRIN, 1'b1);
        stepCheck("st_T7", M_WRITE, 1'b1);

        // BR taken
        runFetch("br1", I_BR, 1'b1, 1'b0);
        stepCheck("br1_T3", M_GRA | M_ROUT | M_CONIN, 1'b1);
        stepCheck("br1_T4", M_PCOUT | M_YIN, 1'b1);
        stepCheck("br1_T5", M_COUT | M_ZIN, 1'b1);
        stepCheck("br1_T6", M_ZLOOUT | M_PCIN, 1'b1);

        // BR not taken; CON is high in T4 only, which must not matter
        runFetch("br0", I_BR, 1'b0, 1'b0);
        stepCheck("br0_T3", M_GRA | M_ROUT | M_CONIN, 1'b1);
        applyStimulus(1'b1, I_BR, 1'b1, 1'b0);
        stepCheck("br0_T4", M_PCOUT | M_YIN, 1'b1);
        applyStimulus(1'b1, I_BR, 1'b0, 1'b0);
        stepCheck("br0_T5", M_COUT | M_ZIN, 1'b1);
        stepCheck("br0_T6", NONE, 1'b1);

        // LDI with Stop raised mid-instruction
        runFetch("ldi", I_LDI, 1'b0, 1'b0);
        stepCheck("ldi_T3", M_GRB | M_BAOUT | M_YIN, 1'b1);
        stepCheck("ldi_T4", M_COUT | M_ZIN, 1'b1);
        applyStimulus(1'b1, I_LDI, 1'b0, 1'b1);
        stepCheck("ldi_T5", M_ZLOOUT | M_GRA | M_RIN, 1'b1);
        stepCheck("stop_0", NONE, 1'b0);
        stepCheck("stop_1", NONE, 1'b0);
        applyStimulus(1'b1, I_LDI, 1'b0, 1'b0);

        // ADDI
        runFetch("addi", I_ADDI, 1'b0, 1'b0);
        stepCheck("addi_T3", M_GRB | M_ROUT | M_YIN, 1'b1);
        stepCheck("addi_T4", M_COUT | M_ZIN, 1'b1);
        stepCheck("addi_T5", M_ZLOOUT | M_GRA | M_RIN, 1'b1);

        // NOP
        runFetch("nop", I_NOP, 1'b0, 1'b0);
        stepCheck("nop_T3", NONE, 1'b1);

        // Illegal opcode pulses IllegalOp for exactly one cycle
        runFetch("bad", I_BAD, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        checkOutput("bad_T3", NONE, 4'd0, 1'b1, 1'b1);

        // HALT holds regardless of Stop until reset
        runFetch("halt", I_HALT, 1'b0, 1'b0);
        stepCheck("halt_T3", NONE, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, I_HALT, i[0], i[1]);
            stepCheck($sformatf("halted_%0d", i), NONE, 1'b0);
        end
        applyStimulus(1'b0, I_LD, 1'b0, 1'b0);
        stepCheck("halt_reset", NONE, 1'b0);
        applyStimulus(1'b1, I_LD, 1'b0, 1'b0);
        stepCheck("after_halt_T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
